// File: rtl/acc_cpu_core_if.sv
// Bus between the accumulator core, its program ROM and the output consumer.
// The master side is the core; the slave side is the ROM plus the consumer.
interface acc_cpu_core_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INSTR_W = 8
);
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH/EXEC/OUT_WAIT/HALT sequencer with Z/C flags,
// a single-write-port register file and a valid/ready output port.
module acc_cpu_core #(
    parameter  int unsigned DATA_W  = 8,
    parameter  int unsigned REG_AW  = 4,
    parameter  int unsigned PC_W    = 8,
    localparam int unsigned INSTR_W = 4 + REG_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    acc_cpu_core_if.master     bus,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    pc,
    output logic               halted
);
    localparam int unsigned NREGS = 1 << REG_AW;

    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_ST  = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_JMP = 4'd11;
    localparam logic [3:0] OP_JZ  = 4'd12;
    localparam logic [3:0] OP_JC  = 4'd13;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_OUT_WAIT, S_HALT} state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] regs [NREGS];
    logic              flag_z, flag_c;

    logic [3:0]        opcode;
    logic [REG_AW-1:0] opr;
    logic [DATA_W-1:0] rdata, imm;
    logic [PC_W-1:0]   tgt;

    logic              do_fetch, do_exec, do_accept;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W:0]   wide;
    logic              c_nxt, upd_z, jump;

    assign opcode        = ir[INSTR_W-1 -: 4];
    assign opr           = ir[REG_AW-1:0];
    assign rdata         = regs[opr];
    assign imm           = DATA_W'(opr);
    assign tgt           = PC_W'(opr);
    assign bus.imem_addr = pc;

    // State register; en freezes the sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    state_nxt = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_HLT)      state_nxt = S_HALT;
                else if (opcode == OP_OUT) state_nxt = S_OUT_WAIT;
                else                       state_nxt = S_FETCH;
            end
            S_OUT_WAIT: if (bus.out_ready) state_nxt = S_FETCH;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        do_fetch  = 1'b0;
        do_exec   = 1'b0;
        do_accept = 1'b0;
        case (state)
            S_FETCH:    do_fetch  = en;
            S_EXEC:     do_exec   = en;
            S_OUT_WAIT: do_accept = en && bus.out_ready;
            default:    ;
        endcase
    end

    // ALU and branch decision for the instruction held in ir
    always_comb begin
        acc_nxt = acc;
        c_nxt   = flag_c;
        upd_z   = 1'b0;
        jump    = 1'b0;
        wide    = '0;
        case (opcode)
            OP_LDI: begin acc_nxt = imm;   upd_z = 1'b1; end
            OP_LD:  begin acc_nxt = rdata; upd_z = 1'b1; end
            OP_ADD: begin
                wide             = {1'b0, acc} + {1'b0, rdata};
                {c_nxt, acc_nxt} = wide;
                upd_z            = 1'b1;
            end
            OP_SUB: begin
                // Bit DATA_W of the extended difference is the borrow
                wide             = {1'b0, acc} - {1'b0, rdata};
                {c_nxt, acc_nxt} = wide;
                upd_z            = 1'b1;
            end
            OP_AND: begin acc_nxt = acc & rdata; upd_z = 1'b1; end
            OP_OR:  begin acc_nxt = acc | rdata; upd_z = 1'b1; end
            OP_XOR: begin acc_nxt = acc ^ rdata; upd_z = 1'b1; end
            OP_SHL: begin
                c_nxt   = acc[DATA_W-1];
                acc_nxt = {acc[DATA_W-2:0], 1'b0};
                upd_z   = 1'b1;
            end
            OP_SHR: begin
                c_nxt   = acc[0];
                acc_nxt = {1'b0, acc[DATA_W-1:1]};
                upd_z   = 1'b1;
            end
            OP_JMP: jump = 1'b1;
            OP_JZ:  jump = flag_z;
            OP_JC:  jump = flag_c;
            default: ;
        endcase
    end

    // Architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= '0;
            ir            <= '0;
            acc           <= '0;
            flag_z        <= 1'b0;
            flag_c        <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            halted        <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[REG_AW'(i)] <= '0;
            end
        end else begin
            if (do_fetch) begin
                ir <= bus.imem_data;
                pc <= pc + PC_W'(1);
            end
            if (do_exec) begin
                acc    <= acc_nxt;
                flag_c <= c_nxt;
                if (upd_z)              flag_z <= (acc_nxt == '0);
                if (jump)               pc <= tgt;
                if (opcode == OP_ST)    regs[opr] <= acc;
                if (opcode == OP_HLT)   halted <= 1'b1;
                if (opcode == OP_OUT) begin
                    bus.out_data  <= acc;
                    bus.out_valid <= 1'b1;
                end
            end
            if (do_accept) bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
- Parametrised multi-cycle accumulator CPU core; successor to the fixed 8-bit fetch/decode/execute core with a 16-entry register file.
- Generalises data width, register count and PC width.
- Adds an explicit FSM, accumulator with Z/C flags, conditional branches, a valid/ready output port, halt, and a run-enable.
- Instruction memory is external and read combinationally. Sits between the program ROM and the downstream output consumer.

Parameters:
DATA_W, 8, accumulator/register/output width (>=4)
REG_AW, 4, register-file address width; 2**REG_AW registers; also operand field width
PC_W, 8, program counter width; must be >= REG_AW
INSTR_W, 4+REG_AW, derived (localparam): opcode[INSTR_W-1 -: 4], operand[REG_AW-1:0]

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
en  input  1  run enable; when 0 all state holds (FSM, PC, regs, outputs)
imem_addr  output  PC_W  instruction address, always equals pc
imem_data  input  INSTR_W  instruction at imem_addr, combinational
ir  output  INSTR_W  instruction register (last fetched instruction)
pc  output  PC_W  program counter
out_data  output  DATA_W  output payload
out_valid  output  1  payload valid
out_ready  input  1  consumer accepts when out_valid && out_ready
halted  output  1  core in HALT state

Behaviour:
- Reset values: pc=0, ir=0, acc=0, Z=0, C=0, all registers=0, out_data=0, out_valid=0, halted=0. FSM goes to FETCH.
- Reset has priority over en and over any state, including OUT_WAIT and HALT.
- FSM states: FETCH, EXEC, OUT_WAIT, HALT. All transitions are gated by en=1.
- FETCH: ir<=imem_data; pc<=pc+1 (wraps modulo 2**PC_W); ->EXEC.
- EXEC: decode ir and act. HLT->HALT; OUT->OUT_WAIT; all other opcodes ->FETCH.
- Normal instruction: 2 cycles (with en held high).
- Operand handling:
  - opr = ir operand field.
  - imm = opr zero-extended (or truncated) to DATA_W.
  - tgt = opr zero-extended to PC_W.
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc<=imm.
  - 2 LD: acc<=R[opr].
  - 3 ST: R[opr]<=acc.
  - 4 ADD: {C,acc}<=acc+R[opr].
  - 5 SUB: acc<=acc-R[opr]; C=1 iff borrow (acc<R[opr] unsigned).
  - 6 AND, 7 OR, 8 XOR: acc<=acc op R[opr]; C unchanged.
  - 9 SHL: C<=acc[MSB]; acc<=acc<<1.
  - 10 SHR: C<=acc[0]; acc<=acc>>1 (logical).
  - 11 JMP: pc<=tgt.
  - 12 JZ: if Z, pc<=tgt.
  - 13 JC: if C, pc<=tgt.
  - 14 OUT: out_data<=acc; out_valid<=1.
  - 15 HLT.
- Flags: Z is updated to (new acc==0) by LDI, LD, ADD, SUB, AND, OR, XOR, SHL, SHR. ST, NOP, jumps and OUT leave Z and C unchanged.
- Branch targets overwrite the pc+1 already taken in FETCH. A not-taken branch falls through to pc+1.
- OUT_WAIT:
  - out_valid=1 and out_data stable until handshake.
  - On out_valid&&out_ready (with en=1): out_valid<=0 in the same edge, ->FETCH.
  - When en=0: hold, and ignore out_ready.
  - out_valid is only ever asserted in OUT_WAIT.
- HALT: halted=1; no fetch; pc, ir and the register file frozen. Exit only via reset.
- Register file: single write port (ST only), asynchronous read.

Test Plan:
- Reset mid-program (assert reset in EXEC after LDI 5) -> next cycle pc=0, acc=0, ir=0, out_valid=0, halted=0, FSM=FETCH.
- Program LDI 7; ST R3; LDI 9; ADD R3; OUT; HLT, with out_ready=1 -> single out_valid pulse, out_data=16 (0x10), C=0, Z=0; halted=1; pc frozen at 6.
- LDI 15; ST R1; LDI 15; ADD R1; SHL (DATA_W=8) -> after ADD acc=30, C=0; then LDI 0; SUB R1 -> acc=241 (0xF1), C=1, Z=0; JC 2 -> pc=2.
- Z-branch: LDI 3; ST R0; LD R0; SUB R0; JZ 10; at addr 10 OUT -> Z=1, branch taken, out_data=0. Repeat with LDI 4 before SUB -> Z=0, JZ not taken, pc=5.
- Backpressure: OUT with out_ready=0 for 5 cycles -> out_valid stays 1, out_data stable, pc unchanged; raise out_ready -> accepted in 1 cycle, next FETCH. Dropping en mid-wait -> freeze, no accept.
- Wrap and params: PC_W=4, REG_AW=3, DATA_W=16; 16 NOPs -> pc wraps 15->0. LDI 7 -> acc=0x0007. JMP 7 -> pc=7.
